// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Bundles every non-clock/reset signal of the fetch stage.
//   Instruction-memory side : imem_req, imem_addr (out), imem_ack, imem_rdata (in)
//   Control-unit side       : Instr, InstrValid (out), InstrReady, PCSrc,
//                             BranchTarget (in)
//   Status                  : PC, PCPlus8, FetchErr (out)
// modport master : the fetch unit itself
// modport slave  : memory + control unit environment
// -----------------------------------------------------------------------------
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        InstrReady;
  logic        PCSrc;
  logic [31:0] BranchTarget;
  logic [31:0] PC;
  logic [31:0] PCPlus8;
  logic        FetchErr;

  modport master (
    output imem_req, imem_addr, Instr, InstrValid, PC, PCPlus8, FetchErr,
    input  imem_ack, imem_rdata, InstrReady, PCSrc, BranchTarget
  );

  modport slave (
    input  imem_req, imem_addr, Instr, InstrValid, PC, PCPlus8, FetchErr,
    output imem_ack, imem_rdata, InstrReady, PCSrc, BranchTarget
  );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: holds the PC, fetches one 32-bit word per request
// over a req/ack handshake and presents it to the control unit with a
// valid/ready handshake. On accept the PC advances by 4 or redirects to
// BranchTarget when PCSrc is set.
//
// Ports:
//   clk      in  clock, rising edge
//   reset_n  in  synchronous active-low reset
//   bus      fetch_unit_if.master (memory, instruction and status signals)
//
// Parameters:
//   RESET_PC   PC loaded on reset (word aligned)
//   WAIT_LIMIT FETCH cycles without ack before FetchErr (2..255)
//
// Optional build macro:
//   ALIGN_CHECK_EN  defined   : misaligned branch target at accept -> ERR
//                   undefined : BranchTarget[1:0] silently forced to 00
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HOLD  = 2'b10,
    ST_ERR   = 2'b11
  } state_t;

  localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [7:0]  r_cnt;
  logic        r_req;
  logic        r_valid;
  logic        r_err;

  state_t      w_next;
  logic [31:0] w_pc_next;
  logic [31:0] w_instr_next;
  logic [7:0]  w_cnt_next;
  logic [31:0] w_target;

  assign w_target = {bus.BranchTarget[31:2], 2'b00};

  // Next-state, next-PC, captured instruction and wait-counter logic.
  always_comb begin
    w_next       = r_state;
    w_pc_next    = r_pc;
    w_instr_next = r_instr;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_next = ST_FETCH;
      end
      ST_FETCH: begin
        // An ack on the limit cycle still wins over the timeout.
        if (bus.imem_ack) begin
          w_instr_next = bus.imem_rdata;
          w_cnt_next   = 8'd0;
          w_next       = ST_HOLD;
        end else if (r_cnt == LIMIT_M1) begin
          w_next = ST_ERR;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      ST_HOLD: begin
        if (bus.InstrReady) begin
`ifdef ALIGN_CHECK_EN
          if (bus.PCSrc && (bus.BranchTarget[1:0] != 2'b00)) begin
            w_next = ST_ERR;
          end else begin
            w_pc_next = bus.PCSrc ? w_target : (r_pc + 32'd4);
            w_next    = ST_FETCH;
          end
`else
          w_pc_next = bus.PCSrc ? w_target : (r_pc + 32'd4);
          w_next    = ST_FETCH;
`endif
        end else begin
          w_next = ST_HOLD;
        end
      end
      ST_ERR: begin
        w_next = ST_ERR;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake flags (decoded from next state).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= 32'h0000_0000;
      r_cnt   <= 8'd0;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_next;
      r_instr <= w_instr_next;
      r_cnt   <= w_cnt_next;
      r_req   <= (w_next == ST_FETCH);
      r_valid <= (w_next == ST_HOLD);
      r_err   <= (w_next == ST_ERR);
    end
  end

  assign bus.imem_req   = r_req;
  assign bus.imem_addr  = r_pc;
  assign bus.Instr      = r_instr;
  assign bus.InstrValid = r_valid;
  assign bus.PC         = r_pc;
  assign bus.PCPlus8    = r_pc + 32'd8;
  assign bus.FetchErr   = r_err;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. Memory returns addr ^ 32'hDEAD_0000, so the
// word at 0x0 is 32'hDEAD_0000, at 0x4 32'hDEAD_0004, at 0x8 32'hDEAD_0008.
// Outputs are sampled 1 time unit after the rising edge; inputs change there.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .WAIT_LIMIT(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_rdata = bus.imem_addr ^ 32'hDEAD_0000;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reset held for two edges, then released; DUT is in IDLE on return.
  task automatic do_reset;
    reset_n = 1'b0;
    bus.imem_ack = 1'b0;
    bus.InstrReady = 1'b0;
    bus.PCSrc = 1'b0;
    bus.BranchTarget = 32'h0;
    step;
    step;
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    n_tests++;
    if (bus.imem_req !== 1'b0 || bus.InstrValid !== 1'b0 || bus.FetchErr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: req=%b valid=%b err=%b required 0 0 0",
               bus.imem_req, bus.InstrValid, bus.FetchErr);
    end
    n_tests++;
    if (bus.PC !== 32'h0 || bus.Instr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_pc_instr: PC=%h Instr=%h required 0 0", bus.PC, bus.Instr);
    end
    n_tests++;
    if (bus.PCPlus8 !== 32'h8) begin
      n_fail++;
      $display("FAIL reset_pcplus8: got %h required 00000008", bus.PCPlus8);
    end
  endtask

  task automatic test_sequential;
    logic [31:0] a;
    do_reset;
    bus.imem_ack = 1'b1;
    bus.InstrReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 32'(i * 4);
      step;
      n_tests++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== a || bus.InstrValid !== 1'b0) begin
        n_fail++;
        $display("FAIL seq_fetch[%0d]: req=%b addr=%h valid=%b required 1 %h 0",
                 i, bus.imem_req, bus.imem_addr, bus.InstrValid, a);
      end
      step;
      n_tests++;
      if (bus.InstrValid !== 1'b1 || bus.imem_req !== 1'b0 ||
          bus.Instr !== (a ^ 32'hDEAD_0000) || bus.PC !== a) begin
        n_fail++;
        $display("FAIL seq_hold[%0d]: valid=%b req=%b Instr=%h PC=%h required 1 0 %h %h",
                 i, bus.InstrValid, bus.imem_req, bus.Instr, bus.PC, a ^ 32'hDEAD_0000, a);
      end
    end
  endtask

  // Runs straight after test_sequential: DUT is in HOLD at PC=0x8, ready=1.
  task automatic test_branch;
    bus.PCSrc = 1'b1;
    bus.BranchTarget = 32'h0000_0100;
    step;
    bus.PCSrc = 1'b0;
    bus.BranchTarget = 32'h0;
    n_tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 || bus.PCPlus8 !== 32'h108) begin
      n_fail++;
      $display("FAIL branch: req=%b addr=%h PCPlus8=%h required 1 00000100 00000108",
               bus.imem_req, bus.imem_addr, bus.PCPlus8);
    end
    step;
    n_tests++;
    if (bus.InstrValid !== 1'b1 || bus.Instr !== 32'hDEAD_0100) begin
      n_fail++;
      $display("FAIL branch_instr: valid=%b Instr=%h required 1 dead0100",
               bus.InstrValid, bus.Instr);
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    bus.imem_ack = 1'b1;
    bus.InstrReady = 1'b0;
    step;
    step;
    // PCSrc/BranchTarget toggled while not accepting must have no effect.
    bus.PCSrc = 1'b1;
    bus.BranchTarget = 32'h0000_0200;
    for (int i = 0; i < 5; i++) begin
      step;
      n_tests++;
      if (bus.InstrValid !== 1'b1 || bus.imem_req !== 1'b0 ||
          bus.PC !== 32'h0 || bus.Instr !== 32'hDEAD_0000) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%b req=%b PC=%h Instr=%h required 1 0 0 dead0000",
                 i, bus.InstrValid, bus.imem_req, bus.PC, bus.Instr);
      end
    end
    bus.PCSrc = 1'b0;
    bus.BranchTarget = 32'h0;
    bus.InstrReady = 1'b1;
    step;
    n_tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4 || bus.InstrValid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: req=%b addr=%h valid=%b required 1 00000004 0",
               bus.imem_req, bus.imem_addr, bus.InstrValid);
    end
  endtask

  task automatic test_timeout;
    do_reset;
    bus.imem_ack = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step;
      n_tests++;
      if (bus.imem_req !== 1'b1 || bus.FetchErr !== 1'b0) begin
        n_fail++;
        $display("FAIL to_wait[%0d]: req=%b err=%b required 1 0", k, bus.imem_req, bus.FetchErr);
      end
    end
    step;
    n_tests++;
    if (bus.FetchErr !== 1'b1 || bus.imem_req !== 1'b0 || bus.InstrValid !== 1'b0) begin
      n_fail++;
      $display("FAIL to_err: err=%b req=%b valid=%b required 1 0 0",
               bus.FetchErr, bus.imem_req, bus.InstrValid);
    end
    // ERR is sticky even if memory and consumer become active.
    bus.imem_ack = 1'b1;
    bus.InstrReady = 1'b1;
    repeat (3) step;
    n_tests++;
    if (bus.FetchErr !== 1'b1 || bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL to_sticky: err=%b req=%b required 1 0", bus.FetchErr, bus.imem_req);
    end
    // Second run: ack arrives on the 16th FETCH cycle and must win.
    do_reset;
    bus.imem_ack = 1'b0;
    repeat (16) step;
    bus.imem_ack = 1'b1;
    step;
    n_tests++;
    if (bus.FetchErr !== 1'b0 || bus.InstrValid !== 1'b1 || bus.Instr !== 32'hDEAD_0000) begin
      n_fail++;
      $display("FAIL to_ack_limit: err=%b valid=%b Instr=%h required 0 1 dead0000",
               bus.FetchErr, bus.InstrValid, bus.Instr);
    end
  endtask

  task automatic test_wrap_misalign;
    do_reset;
    bus.imem_ack = 1'b1;
    bus.InstrReady = 1'b1;
    step;
    step;
    bus.PCSrc = 1'b1;
    bus.BranchTarget = 32'hFFFF_FFFC;
    step;
    bus.PCSrc = 1'b0;
    bus.BranchTarget = 32'h0;
    n_tests++;
    if (bus.imem_addr !== 32'hFFFF_FFFC || bus.PCPlus8 !== 32'h0000_0004) begin
      n_fail++;
      $display("FAIL wrap_top: addr=%h PCPlus8=%h required fffffffc 00000004",
               bus.imem_addr, bus.PCPlus8);
    end
    step;
    step;
    n_tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_zero: req=%b addr=%h required 1 00000000", bus.imem_req, bus.imem_addr);
    end
    step;
    bus.PCSrc = 1'b1;
    bus.BranchTarget = 32'h0000_0102;
    step;
    bus.PCSrc = 1'b0;
    bus.BranchTarget = 32'h0;
    n_tests++;
`ifdef ALIGN_CHECK_EN
    if (bus.FetchErr !== 1'b1 || bus.imem_req !== 1'b0 || bus.PC !== 32'h0) begin
      n_fail++;
      $display("FAIL misalign_err: err=%b req=%b PC=%h required 1 0 00000000",
               bus.FetchErr, bus.imem_req, bus.PC);
    end
`else
    if (bus.FetchErr !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL misalign_force: err=%b req=%b addr=%h required 0 1 00000100",
               bus.FetchErr, bus.imem_req, bus.imem_addr);
    end
`endif
  endtask

  task automatic test_reset_mid;
    do_reset;
    bus.imem_ack = 1'b1;
    bus.InstrReady = 1'b1;
    step;
    step;
    bus.PCSrc = 1'b1;
    bus.BranchTarget = 32'h0000_0040;
    bus.imem_ack = 1'b0;
    step;
    bus.PCSrc = 1'b0;
    bus.BranchTarget = 32'h0;
    step;
    n_tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL rmid_wait: req=%b addr=%h required 1 00000040", bus.imem_req, bus.imem_addr);
    end
    // Reset coincides with an ack; the returned word must be discarded.
    reset_n = 1'b0;
    bus.imem_ack = 1'b1;
    step;
    n_tests++;
    if (bus.PC !== 32'h0 || bus.InstrValid !== 1'b0 || bus.imem_req !== 1'b0 ||
        bus.Instr !== 32'h0) begin
      n_fail++;
      $display("FAIL rmid_reset: PC=%h valid=%b req=%b Instr=%h required 0 0 0 0",
               bus.PC, bus.InstrValid, bus.imem_req, bus.Instr);
    end
    reset_n = 1'b1;
    step;
    n_tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL rmid_restart: req=%b addr=%h required 1 00000000",
               bus.imem_req, bus.imem_addr);
    end
  endtask

  initial begin
    bus.imem_ack = 1'b0;
    bus.InstrReady = 1'b0;
    bus.PCSrc = 1'b0;
    bus.BranchTarget = 32'h0;
    test_reset;
    test_sequential;
    test_branch;
    test_backpressure;
    test_timeout;
    test_wrap_misalign;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
